// File: rtl/mux_arb_2x1.sv
// mux_arb_2x1
// -----------
// Merges two valid-qualified byte streams into one registered output
// stream. Each lane is buffered in its own small FIFO and a round-robin
// arbiter drains both FIFOs, one word per cycle, into dataOut.
//
// Parameters:
//   DATA_WIDTH  width of every data port and FIFO entry
//   DEPTH       entries per lane FIFO (power of two, >= 2)
//   AF_THRESH   almostFullN asserts when FIFO N occupancy >= AF_THRESH
//
// Ports:
//   clk          single clock, all state on the rising edge
//   reset        asynchronous, active-low reset
//   dataIn0/1    lane write data
//   validIn0/1   lane write strobes
//   pause        downstream stall, 1 = no pop this cycle
//   fullOut0/1   FIFO occupancy == DEPTH
//   almostFull0/1 FIFO occupancy >= AF_THRESH
//   dataOut      merged data (registered)
//   validOut     dataOut holds a new word this cycle
//   srcOut       lane that supplied the current dataOut
//
// Optional build macro MUX_ARB_OVF_EN adds sticky per-lane overflow flags
// ovf0/ovf1 (set when a lane word is dropped) and their clear input ovfClr.

module mux_arb_2x1 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef MUX_ARB_OVF_EN
    input  logic                  ovfClr,
    output logic                  ovf0,
    output logic                  ovf1,
`endif
    input  logic [DATA_WIDTH-1:0] dataIn0,
    input  logic                  validIn0,
    input  logic [DATA_WIDTH-1:0] dataIn1,
    input  logic                  validIn1,
    input  logic                  pause,
    output logic                  fullOut0,
    output logic                  fullOut1,
    output logic                  almostFull0,
    output logic                  almostFull1,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  validOut,
    output logic                  srcOut
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Per-lane FIFO storage and bookkeeping, indexed by lane number.
    logic [DATA_WIDTH-1:0] mem     [2][DEPTH];
    logic [PW-1:0]         wrPtr   [2];
    logic [PW-1:0]         rdPtr   [2];
    logic [CW-1:0]         count   [2];
    logic [DATA_WIDTH-1:0] dataIn  [2];
    logic [1:0]            validIn;

    logic [1:0]            notEmpty;
    logic [1:0]            pop;
    logic [1:0]            accept;
    logic                  grantValid;
    logic                  grantLane;
    logic                  lastGrant;
    logic [DATA_WIDTH-1:0] headData;

    assign dataIn[0] = dataIn0;
    assign dataIn[1] = dataIn1;
    assign validIn   = {validIn1, validIn0};

    // Arbitration and push acceptance, all derived from registered counts.
    // With both lanes non-empty the lane that did not win last time is
    // chosen, giving strict alternation. A push into a full FIFO is still
    // accepted when that FIFO pops in the same cycle, since a slot frees up.
    always_comb begin
        notEmpty   = {count[1] != '0, count[0] != '0};
        grantValid = 1'b0;
        grantLane  = 1'b0;
        pop        = 2'b00;
        accept     = 2'b00;
        if (!pause && (notEmpty != 2'b00)) begin
            grantValid = 1'b1;
            if (notEmpty == 2'b11) begin
                grantLane = ~lastGrant;
            end else begin
                grantLane = notEmpty[1];
            end
        end
        if (grantValid) begin
            pop[grantLane] = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            accept[i] = validIn[i] && ((count[i] != CW'(DEPTH)) || pop[i]);
        end
    end

    assign headData = mem[grantLane][rdPtr[grantLane]];

    // FIFO pointers and occupancy. Pointers are PW bits wide so they wrap
    // modulo DEPTH on their own; a simultaneous push and pop leaves the
    // occupancy unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                wrPtr[i] <= '0;
                rdPtr[i] <= '0;
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (accept[i]) begin
                    wrPtr[i] <= wrPtr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rdPtr[i] <= rdPtr[i] + PW'(1);
                end
                case ({accept[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO data array. Not reset: contents are only ever read behind the
    // read pointer, which reset returns to the empty state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (accept[i]) begin
                mem[i][wrPtr[i]] <= dataIn[i];
            end
        end
    end

    // Registered output stage. Without a grant only validOut drops; dataOut
    // and srcOut keep the last delivered word. lastGrant resets to 1 so that
    // lane 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut   <= '0;
            validOut  <= 1'b0;
            srcOut    <= 1'b0;
            lastGrant <= 1'b1;
        end else if (grantValid) begin
            dataOut   <= headData;
            validOut  <= 1'b1;
            srcOut    <= grantLane;
            lastGrant <= grantLane;
        end else begin
            validOut  <= 1'b0;
        end
    end

    assign fullOut0    = (count[0] == CW'(DEPTH));
    assign fullOut1    = (count[1] == CW'(DEPTH));
    assign almostFull0 = (count[0] >= CW'(AF_THRESH));
    assign almostFull1 = (count[1] >= CW'(AF_THRESH));

`ifdef MUX_ARB_OVF_EN
    logic [1:0] drop;

    assign drop = validIn & ~accept;

    // Sticky overflow flags. A drop in the same cycle as a clear wins, so
    // no drop event is ever lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf0 <= 1'b0;
            ovf1 <= 1'b0;
        end else begin
            if (drop[0]) begin
                ovf0 <= 1'b1;
            end else if (ovfClr) begin
                ovf0 <= 1'b0;
            end
            if (drop[1]) begin
                ovf1 <= 1'b1;
            end else if (ovfClr) begin
                ovf1 <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: doc/mux_arb_2x1.md
Name: mux_arb_2x1

Overview:
- Two-input to one-output merger for valid-qualified byte streams; the inverse of the 1:2 valid-steered demultiplexer on the same datapath.
- Each input is buffered in its own small FIFO.
- A round-robin arbiter drains both FIFOs into a single registered output stream.
- Sits where two lanes recombine before the downstream stage; exposes full/almost-full flags back to the upstream senders.

Parameters:
- DATA_WIDTH, 8, width of every data port and FIFO entry.
- DEPTH, 4, entries per input FIFO; power of two, >= 2.
- AF_THRESH, 3, almostFullN asserts when FIFO N occupancy >= AF_THRESH; range 1..DEPTH.

Ports:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- dataIn0  input  DATA_WIDTH  lane 0 write data.
- validIn0  input  1  lane 0 write strobe.
- dataIn1  input  DATA_WIDTH  lane 1 write data.
- validIn1  input  1  lane 1 write strobe.
- pause  input  1  downstream stall; 1 = no pop this cycle.
- fullOut0  output  1  FIFO 0 occupancy == DEPTH.
- fullOut1  output  1  FIFO 1 occupancy == DEPTH.
- almostFull0  output  1  FIFO 0 occupancy >= AF_THRESH.
- almostFull1  output  1  FIFO 1 occupancy >= AF_THRESH.
- dataOut  output  DATA_WIDTH  merged data, registered.
- validOut  output  1  dataOut holds a new word this cycle.
- srcOut  output  1  lane that supplied the current dataOut.

Behaviour:
- Reset (reset==0, async):
  - Counts, read/write pointers, dataOut, validOut and srcOut go to 0.
  - lastGrant goes to 1, so lane 0 wins the first tie.
  - Flags are derived from counts, so full and almost-full read 0.
  - Reset mid-stream discards all buffered words; no partial output.
- Push:
  - At an edge with validInN==1, the word enters FIFO N if count<DEPTH, or if FIFO N pops in the same cycle.
  - Otherwise the word is dropped and FIFO state is unchanged.
- Grant (combinational from registered counts):
  - If pause==1, or both FIFOs are empty, there is no grant.
  - If exactly one FIFO is non-empty, that lane is granted.
  - If both are non-empty, the lane != lastGrant is granted (strict alternation).
- Pop: on a grant, at the next edge:
  - The head of the granted FIFO loads into dataOut.
  - validOut<=1, srcOut<=lane, lastGrant<=lane.
  - The read pointer advances.
- No grant: validOut<=0; dataOut and srcOut hold their previous values.
- Latency: a word captured at edge k into an empty FIFO, with no competition and pause low, appears with validOut=1 after edge k+1. There is no same-edge bypass.
- Same-cycle push and pop on one FIFO: occupancy unchanged; the push is accepted even when full.
- Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits wide.
- Sustained throughput: one word per cycle total while pause==0 and either FIFO is non-empty.
- pause asserted mid-burst: validOut drops at the next edge and FIFO contents are retained; draining resumes in round-robin order from lastGrant.

Optional Feature:
- Macro: MUX_ARB_OVF_EN.
- Defined:
  - Adds ports ovf0/ovf1 (output, 1) and ovfClr (input, 1).
  - ovfN sets at the edge where a lane-N word is dropped (the Push drop condition), and stays set until an edge with ovfClr==1.
  - If set and clear occur in the same cycle, set wins.
  - Both flags reset to 0.
- Undefined: the ports and logic are absent; drops are silent.

Test Plan:
- Reset then a single word: release reset; validIn0=1, dataIn0=0xA5 for one cycle -> after the next edge dataOut=0xA5, validOut=1, srcOut=0; the following cycle validOut=0 and dataOut holds 0xA5.
- Round-robin tie: preload lane0={0x01,0x02}, lane1={0x11,0x12} under pause=1, then drop pause -> output sequence 0x01,0x11,0x02,0x12 with srcOut 0,1,0,1 on four consecutive cycles.
- Full/drop (DEPTH=4, pause=1): push 5 words 0x20..0x24 to lane 1 -> fullOut1=1 after the 4th, almostFull1=1 after the 3rd, 0x24 dropped (ovf1=1 with MUX_ARB_OVF_EN); drain yields 0x20..0x23 only.
- Push while full with pop: lane 0 full, pause=0, validIn0=1 with 0x55 in the same cycle -> accepted; occupancy stays 4; 0x55 emerges 4th after the current head.
- Async reset mid-stream: with both FIFOs holding 2 words, pulse reset low between edges -> validOut, dataOut and flags are 0 immediately; after release, no stale words appear, and the first tie goes to lane 0.
- Pause mid-burst: lane 1 streaming alone, assert pause for 3 cycles -> validOut=0 for exactly those cycles, no data lost or reordered.
